// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction tester.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        GO   = 3'd2,
        DONE = 3'd3,
        FOUL = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // BCD value with the lowest 'digits' nibbles set to 9 (up to 8 digits).
    function automatic logic [31:0] bcd_all9(input int unsigned digits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'h9;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reaction_tester_mp_bcd_counter.sv
// Multi-digit BCD counter that saturates at all 9s; clr has priority over inc.
module bcd_counter
    import reaction_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   value
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] ALL9 = W'(bcd_all9(DIGITS));

    logic [W-1:0] val_q, val_d;
    logic         carry_c;

    // Ripple-carry BCD increment, held at all 9s instead of wrapping.
    always_comb begin
        val_d   = val_q;
        carry_c = 1'b1;
        if (clr) begin
            val_d = '0;
        end else if (inc && (val_q != ALL9)) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (carry_c) begin
                    if (val_q[4*i +: 4] == 4'd9) begin
                        val_d[4*i +: 4] = 4'd0;
                    end else begin
                        val_d[4*i +: 4] = val_q[4*i +: 4] + 4'd1;
                        carry_c         = 1'b0;
                    end
                end
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign value = val_q;

endmodule

// File: rtl/reaction_tester_mp.sv
// Multi-player reaction tester: random arm delay, GO timing in BCD, first-press
// latch with tie/foul detection, and best-time record.
module reaction_tester_mp
    import reaction_pkg::*;
#(
    parameter int unsigned N_PLAYERS  = 4,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DELAY_MIN  = 1000,
    parameter logic [15:0] DELAY_MASK = 16'h07FF,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear_best,
    input  logic [N_PLAYERS-1:0]  press,
    output logic                  led_go,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic [2:0]            winner,
    output logic                  tie,
    output logic                  foul,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DLY_W = $clog2(DELAY_MIN + 32'h10000);
    localparam logic [W-1:0] ALL9 = W'(bcd_all9(DIGITS));

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic [N_PLAYERS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [2:0]             winner_q, winner_d;
    logic                   tie_q, tie_d;
    logic [W-1:0]           best_q, best_d;
    logic                   upd_q, upd_d;
    logic                   led_go_q, led_go_d, foul_q, foul_d;
    logic                   done_q, done_d, busy_q, busy_d;

    logic [N_PLAYERS-1:0]   rise_c;
    logic                   any_rise_c, multi_c, tick_c, cnt_inc_c, cnt_clr_c;
    logic [2:0]             enc_c;
    logic [W-1:0]           time_c;

    // Press synchroniser chain and free-running Galois LFSR.
    always_comb begin
        sync1_d = press;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Rising-edge detect, lowest-index priority encoder and multi-press flag.
    always_comb begin
        rise_c     = sync2_q & ~sync3_q;
        any_rise_c = |rise_c;
        multi_c    = |(rise_c & (rise_c - N_PLAYERS'(1)));
        enc_c      = 3'd0;
        for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
            if (rise_c[i]) begin
                enc_c = 3'(i);
            end
        end
    end

    // Millisecond tick divider, running only in WAIT/GO and cleared on state entry.
    always_comb begin
        tick_c = ((state_q == WAIT) || (state_q == GO)) && (div_q == DIV_W'(TICK_DIV - 1));
        div_d  = '0;
        if ((state_d == state_q) && ((state_q == WAIT) || (state_q == GO))) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
        end
    end

    // Next-state, delay countdown, winner latch and registered status outputs.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        winner_d  = winner_q;
        tie_d     = tie_q;
        cnt_inc_c = 1'b0;
        cnt_clr_c = 1'b0;
        case (state_q)
            IDLE, DONE, FOUL: begin
                if (start) begin
                    state_d   = WAIT;
                    dly_d     = DLY_W'(DELAY_MIN) + DLY_W'(lfsr_q & DELAY_MASK);
                    winner_d  = 3'd0;
                    tie_d     = 1'b0;
                    cnt_clr_c = 1'b1;
                end
            end
            WAIT: begin
                if (any_rise_c) begin
                    state_d   = FOUL;
                    winner_d  = enc_c;
                    tie_d     = multi_c;
                    cnt_clr_c = 1'b1;
                end else if (tick_c) begin
                    if (dly_q <= DLY_W'(1)) begin
                        state_d = GO;
                        dly_d   = '0;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
            end
            GO: begin
                if (any_rise_c) begin
                    state_d  = DONE;
                    winner_d = enc_c;
                    tie_d    = multi_c;
                end else if (tick_c) begin
                    cnt_inc_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        led_go_d = (state_d == GO);
        foul_d   = (state_d == FOUL);
        done_d   = (state_d == DONE);
        busy_d   = (state_d == WAIT) || (state_d == GO);
        upd_d    = (state_d == DONE) && (state_q != DONE);
    end

    // Best-time update in the first DONE cycle; clear_best overrides it.
    always_comb begin
        best_d = best_q;
        if (upd_q && (time_c < best_q)) begin
            best_d = time_c;
        end
        if (clear_best) begin
            best_d = ALL9;
        end
    end

    // State and datapath registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            div_q    <= '0;
            dly_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            winner_q <= 3'd0;
            tie_q    <= 1'b0;
            best_q   <= ALL9;
            upd_q    <= 1'b0;
            led_go_q <= 1'b0;
            foul_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            div_q    <= div_d;
            dly_q    <= dly_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            best_q   <= best_d;
            upd_q    <= upd_d;
            led_go_q <= led_go_d;
            foul_q   <= foul_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_time (
        .clk   (sysclk),
        .rst_n (reset),
        .inc   (cnt_inc_c),
        .clr   (cnt_clr_c),
        .value (time_c)
    );

    assign led_go   = led_go_q;
    assign time_bcd = time_c;
    assign best_bcd = best_q;
    assign winner   = winner_q;
    assign tie      = tie_q;
    assign foul     = foul_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reaction_tester_mp.sv
// Directed bench for reaction_tester_mp (TICK_DIV=10, DELAY_MIN=20, DELAY_MASK=0).
module tb_reaction_tester_mp;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        clear_best = 1'b0;
    logic [3:0]  press = 4'b0000;
    logic        led_go, tie, foul, done, busy;
    logic [15:0] time_bcd, best_bcd;
    logic [2:0]  winner;

    logic        start2 = 1'b0;
    logic        clear_best2 = 1'b0;
    logic [3:0]  press2 = 4'b0000;
    logic        led_go2, tie2, foul2, done2, busy2;
    logic [7:0]  time_bcd2, best_bcd2;
    logic [2:0]  winner2;

    int errors = 0;
    int checks = 0;
    int lat;
    logic saw;

    always #5 sysclk = ~sysclk;

    reaction_tester_mp #(
        .N_PLAYERS (4), .TICK_DIV (10), .DIGITS (4),
        .DELAY_MIN (20), .DELAY_MASK (16'h0000), .LFSR_SEED (16'hACE1)
    ) dut (
        .sysclk (sysclk), .reset (reset), .start (start), .clear_best (clear_best),
        .press (press), .led_go (led_go), .time_bcd (time_bcd), .best_bcd (best_bcd),
        .winner (winner), .tie (tie), .foul (foul), .done (done), .busy (busy)
    );

    // Two-digit instance so saturation is reached in a short run.
    reaction_tester_mp #(
        .N_PLAYERS (4), .TICK_DIV (10), .DIGITS (2),
        .DELAY_MIN (20), .DELAY_MASK (16'h0000), .LFSR_SEED (16'hACE1)
    ) dut_sat (
        .sysclk (sysclk), .reset (reset), .start (start2), .clear_best (clear_best2),
        .press (press2), .led_go (led_go2), .time_bcd (time_bcd2), .best_bcd (best_bcd2),
        .winner (winner2), .tie (tie2), .foul (foul2), .done (done2), .busy (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
    endtask

    // Arm, wait for GO (bounded), press 'k' cycles after GO, settle 6 cycles.
    task automatic play_round(input int k, input logic [3:0] pat);
        pulse_start();
        lat = 0;
        while (led_go !== 1'b1 && lat < 400) begin
            tick_n(1);
            lat++;
        end
        chk("go_latency_200", 32'((lat >= 199) && (lat <= 201)), 32'd1);
        tick_n(k);
        press = pat;
        tick_n(6);
    endtask

    initial begin
        // Reset values
        tick_n(3);
        chk("rst_led_go", 32'(led_go), 32'd0);
        chk("rst_time", 32'(time_bcd), 32'h0000);
        chk("rst_best", 32'(best_bcd), 32'h9999);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_tie", 32'(tie), 32'd0);
        chk("rst_foul", 32'(foul), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick_n(3);

        // Nominal round: 12 ms
        play_round(125, 4'b0100);
        chk("r1_done", 32'(done), 32'd1);
        chk("r1_winner", 32'(winner), 32'd2);
        chk("r1_tie", 32'(tie), 32'd0);
        chk("r1_time", 32'(time_bcd), 32'h0012);
        chk("r1_best", 32'(best_bcd), 32'h0012);
        chk("r1_led_go", 32'(led_go), 32'd0);
        chk("r1_busy", 32'(busy), 32'd0);
        press = 4'b0000;
        tick_n(4);

        // Slower round: best unchanged
        play_round(300, 4'b0001);
        chk("r2_time", 32'(time_bcd), 32'h0030);
        chk("r2_winner", 32'(winner), 32'd0);
        chk("r2_best", 32'(best_bcd), 32'h0012);
        press = 4'b0000;
        tick_n(4);

        // Faster round: best improves
        play_round(70, 4'b1000);
        chk("r3_time", 32'(time_bcd), 32'h0007);
        chk("r3_winner", 32'(winner), 32'd3);
        chk("r3_best", 32'(best_bcd), 32'h0007);
        press = 4'b0000;
        tick_n(4);

        // clear_best
        clear_best = 1'b1;
        tick_n(1);
        clear_best = 1'b0;
        chk("clr_best", 32'(best_bcd), 32'h9999);
        chk("clr_done_held", 32'(done), 32'd1);

        // Tie: players 3 and 1 together
        play_round(30, 4'b1010);
        chk("tie_winner", 32'(winner), 32'd1);
        chk("tie_flag", 32'(tie), 32'd1);
        chk("tie_time", 32'(time_bcd), 32'h0003);
        chk("tie_best", 32'(best_bcd), 32'h0003);
        press = 4'b0000;
        tick_n(4);

        // False start
        pulse_start();
        chk("fs_busy", 32'(busy), 32'd1);
        chk("fs_winner_clr", 32'(winner), 32'd0);
        chk("fs_tie_clr", 32'(tie), 32'd0);
        chk("fs_time_clr", 32'(time_bcd), 32'h0000);
        tick_n(50);
        press = 4'b0010;
        tick_n(5);
        chk("fs_foul", 32'(foul), 32'd1);
        chk("fs_winner", 32'(winner), 32'd1);
        chk("fs_tie", 32'(tie), 32'd0);
        chk("fs_time", 32'(time_bcd), 32'h0000);
        chk("fs_done", 32'(done), 32'd0);
        chk("fs_busy_low", 32'(busy), 32'd0);
        press = 4'b0000;
        saw = 1'b0;
        for (int i = 0; i < 250; i++) begin
            tick_n(1);
            saw = saw | led_go;
        end
        chk("fs_no_go", 32'(saw), 32'd0);
        chk("fs_foul_held", 32'(foul), 32'd1);

        // Saturation on the two-digit instance
        start2 = 1'b1;
        tick_n(1);
        start2 = 1'b0;
        tick_n(1300);
        chk("sat_time", 32'(time_bcd2), 32'h99);
        chk("sat_led_go", 32'(led_go2), 32'd1);
        tick_n(200);
        chk("sat_time_held", 32'(time_bcd2), 32'h99);
        chk("sat_busy", 32'(busy2), 32'd1);

        // Reset mid-GO
        pulse_start();
        lat = 0;
        while (led_go !== 1'b1 && lat < 400) begin
            tick_n(1);
            lat++;
        end
        chk("mid_go_reached", 32'(led_go), 32'd1);
        tick_n(20);
        #3 reset = 1'b0;
        #1;
        chk("mid_led_go", 32'(led_go), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_best", 32'(best_bcd), 32'h9999);
        chk("mid_time", 32'(time_bcd), 32'h0000);
        tick_n(1);
        pulse_start();
        chk("mid_start_ignored", 32'(busy), 32'd0);
        tick_n(2);
        reset = 1'b1;
        tick_n(2);
        chk("post_rst_idle", 32'(busy), 32'd0);
        play_round(125, 4'b0100);
        chk("post_done", 32'(done), 32'd1);
        chk("post_winner", 32'(winner), 32'd2);
        chk("post_time", 32'(time_bcd), 32'h0012);
        chk("post_best", 32'(best_bcd), 32'h0012);
        press = 4'b0000;
        tick_n(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reaction_tester_mp.md
Name: reaction_tester_mp

Overview:
- Parametrised multi-player successor to the single-button reaction-speed tester.
- Arms on a start pulse and waits a pseudo-random delay, then lights the GO LED and counts elapsed milliseconds in BCD.
- Latches the first player to press, detects false starts and keeps a best-time record.
- Sits between the debounced button inputs and the existing 7-segment scan/display block, which consumes the BCD digits.

Parameters:
- N_PLAYERS, 4, number of press inputs (1..8)
- TICK_DIV, 100000, sysclk cycles per 1 ms tick
- DIGITS, 4, BCD digits in the time counter
- DELAY_MIN, 1000, minimum wait in ms ticks
- DELAY_MASK, 16'h07FF, mask applied to the LFSR value and added to DELAY_MIN
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- sysclk, in, 1, system clock
- reset, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle arm/restart pulse (synchronous)
- clear_best, in, 1, one-cycle pulse that sets best time to all-9s
- press, in, N_PLAYERS, raw button levels; asynchronous, synchronised internally
- led_go, out, 1, high in GO state
- time_bcd, out, 4*DIGITS, current/captured reaction time, BCD
- best_bcd, out, 4*DIGITS, best recorded time, BCD
- winner, out, 3, index of the winning or fouling player
- tie, out, 1, more than one new press in the winning cycle
- foul, out, 1, high in FOUL state
- done, out, 1, high in DONE state
- busy, out, 1, high in WAIT or GO

Behaviour:
- Reset is asynchronous, active-low and applies while reset=0. Values in reset:
  - state=IDLE; all outputs 0, except best_bcd=all 9s.
  - LFSR=LFSR_SEED; tick divider=0; synchronisers=0.
- press path: 2-flop synchroniser per bit, then rising-edge detect (rise = sync & ~sync_d). Raw edge to rise therefore takes 3 sysclk edges.
- LFSR: 16-bit Galois, taps 16'hB400. It advances every cycle and never stalls.
- Tick divider:
  - Counts 0..TICK_DIV-1 only in WAIT and GO.
  - Cleared on every state entry.
  - tick=1 when the divider reaches TICK_DIV-1.
- States:
  - IDLE:
    - start -> WAIT. On this transition, delay_cnt = DELAY_MIN + (LFSR & DELAY_MASK) and time_bcd=0.
  - WAIT:
    - delay_cnt decrements on each tick.
    - delay_cnt reaches 0 on a tick -> GO.
    - Any rise -> FOUL; winner = lowest set index; tie = popcount(rise)>1.
    - A rise takes priority over delay expiry in the same cycle.
  - GO:
    - led_go=1.
    - time_bcd increments on each tick: BCD ripple, saturating at all 9s with no wrap.
    - Any rise -> DONE; winner = lowest set index; tie as above; time_bcd frozen at its value in the rise cycle. A tick in the same cycle is not counted.
  - DONE:
    - done=1.
    - One cycle after entry, best_bcd is updated if time_bcd < best_bcd (strict compare).
    - start -> WAIT (re-arm).
  - FOUL:
    - foul=1; time_bcd=0.
    - start -> WAIT.
- start is ignored in WAIT and GO.
- clear_best takes effect in any state, one cycle later. If clear_best and a best-time update fall in the same cycle, clear_best wins.
- winner, tie and time_bcd hold their values until the next WAIT entry, which clears winner and tie.
- Reset mid-operation: immediate return to IDLE with all reset values. best_bcd is also lost.

Decomposition:
- Package reaction_pkg holds:
  - state encoding (IDLE=0, WAIT=1, GO=2, DONE=3, FOUL=4);
  - LFSR_TAPS;
  - the BCD all-9s constant function.
- Sub-module bcd_counter (DIGITS parameter; inputs inc and clr; outputs a saturating BCD value) is instantiated for time_bcd.
- Best-time compare and the priority encoder stay in the top module.

Test Plan:
- All tests use TICK_DIV=10, DELAY_MIN=20, DELAY_MASK=0, N_PLAYERS=4.
- Nominal: reset pulse, then start. led_go rises 200 cycles after WAIT entry (±1). press[2] is raised 125 cycles after GO -> done=1, winner=2, time_bcd=16'h0012, best_bcd=16'h0012.
- False start: start, then press[1] raised 50 cycles into WAIT -> foul=1, winner=1, led_go never rises, time_bcd=0.
- Tie and priority: in GO, press[3] and press[1] rise on the same cycle -> winner=1, tie=1.
- Best tracking: a second round with reaction 30 ms leaves best_bcd at 0x0012. A third round at 7 ms gives best_bcd=0x0007. clear_best then gives best_bcd=0x9999.
- Saturation: no press for 100000 cycles in GO -> time_bcd stops at 0x9999 and stays there.
- Reset mid-GO: reset=0 asserted asynchronously (between clock edges) -> led_go=0 and state IDLE immediately. start is then ignored until reset=1, and the next round behaves as nominal.
